// File: rtl/alu_mdu_if.sv
// rtl/alu_mdu_if.sv - request/result bundle between an issuing pipeline and the multiply/divide unit
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - multi-cycle multiply/divide unit with HI/LO result registers
// Operands are captured at launch; the result is formed from the captured copies on the final edge.
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    alu_mdu_if.slave    bus
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state, w_next_state;
    logic [CW-1:0]    r_cnt, w_next_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
    logic             r_done, r_div_zero;
    logic             w_accept, w_complete, w_mthi, w_mtlo;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    if (!bus.op[2]) begin
                        w_accept     = 1'b1;
                        w_next_state = RUN;
                        w_next_cnt   = bus.op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                    end else if (bus.op == 3'd4) begin
                        w_mthi = 1'b1;
                    end else if (bus.op == 3'd5) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == CW'(1)) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // r_op[0] set means the unsigned variant; r_op[1] set means divide.
    logic                 w_signed, w_neg_a, w_neg_b, w_b_zero;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_divisor, w_q_mag, w_r_mag, w_quot, w_rem;
    logic [2*WIDTH-1:0]   w_ext_a, w_ext_b, w_prod;
    logic [WIDTH-1:0]     w_res_hi, w_res_lo;

    always_comb begin
        w_signed  = ~r_op[0];
        w_neg_a   = w_signed & r_a[WIDTH-1];
        w_neg_b   = w_signed & r_b[WIDTH-1];
        w_b_zero  = (r_b == '0);
        w_ext_a   = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
        w_ext_b   = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
        w_prod    = w_ext_a * w_ext_b;
        // Sign-magnitude division: most-negative / -1 wraps back to most-negative with zero remainder.
        w_abs_a   = w_neg_a ? (WIDTH'(0) - r_a) : r_a;
        w_abs_b   = w_neg_b ? (WIDTH'(0) - r_b) : r_b;
        w_divisor = w_b_zero ? WIDTH'(1) : w_abs_b;
        w_q_mag   = w_abs_a / w_divisor;
        w_r_mag   = w_abs_a % w_divisor;
        w_quot    = (w_neg_a ^ w_neg_b) ? (WIDTH'(0) - w_q_mag) : w_q_mag;
        w_rem     = w_neg_a ? (WIDTH'(0) - w_r_mag) : w_r_mag;
        if (!r_op[1]) begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (w_b_zero) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_accept) begin
                r_op <= bus.op[1:0];
                r_a  <= bus.a;
                r_b  <= bus.b;
            end
            if (w_complete) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
                if (r_op[1]) begin
                    r_div_zero <= w_b_zero;
                end
            end
            if (w_mthi) begin
                r_hi <= bus.a;
            end
            if (w_mtlo) begin
                r_lo <= bus.a;
            end
        end
    end

    assign bus.busy     = (r_state == RUN);
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - randomized self-checking bench for alu_mdu against an arithmetic reference model
module tb_alu_mdu;
    localparam int W    = 32;
    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint      sa, sb, q, r;
        logic [63:0] p;
        rh = '0;
        rl = '0;
        if (op == 3'd0) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            rh = p[63:32];
            rl = p[31:0];
        end else if (op == 3'd1) begin
            p  = {32'b0, a} * {32'b0, b};
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 0) begin
            rh = a;
            rl = '1;
        end else begin
            sa = (op == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
            sb = (op == 3'd2) ? longint'($signed(b)) : longint'({32'b0, b});
            q  = sa / sb;
            r  = sa % sb;
            rh = r[31:0];
            rl = q[31:0];
        end
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ehi, elo;
        int n;
        model(op, a, b, ehi, elo);
        n = op[1] ? DIVC : MULC;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cancel = 1'b0;
        step();
        for (int k = 0; k < n; k++) begin
            total++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                bad++;
                $display("FAIL run_hold op=%0d k=%0d busy=%b done=%b hi=%h lo=%h required busy=1 done=0 hi=%h lo=%h",
                         op, k, bus.busy, bus.done, bus.hi, bus.lo, exp_hi, exp_lo);
            end
            bus.start = 1'($urandom); bus.op = 3'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
            step();
        end
        bus.start = 1'b0;
        exp_hi = ehi;
        exp_lo = elo;
        if (op[1]) exp_dz = (b == 0);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.hi !== exp_hi || bus.lo !== exp_lo || bus.div_zero !== exp_dz) begin
            bad++;
            $display("FAIL result op=%0d a=%h b=%h busy=%b done=%b hi=%h lo=%h dz=%b required busy=0 done=1 hi=%h lo=%h dz=%b",
                     op, a, b, bus.busy, bus.done, bus.hi, bus.lo, bus.div_zero, exp_hi, exp_lo, exp_dz);
        end
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            bad++;
            $display("FAIL after_done busy=%b done=%b hi=%h lo=%h required busy=0 done=0 hi=%h lo=%h",
                     bus.busy, bus.done, bus.hi, bus.lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            bad++;
            $display("FAIL reset_state busy=%b done=%b dz=%b hi=%h lo=%h required all zero",
                     bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
        end
    endtask

    task automatic test_directed();
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        total++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
            bad++; $display("FAIL mult_vec hi=%h lo=%h required ffffffff fffffffa", bus.hi, bus.lo);
        end
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        total++;
        if (bus.hi !== 32'h0000_0002 || bus.lo !== 32'hFFFF_FFFA) begin
            bad++; $display("FAIL multu_vec hi=%h lo=%h required 00000002 fffffffa", bus.hi, bus.lo);
        end
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        total++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL div_vec hi=%h lo=%h required ffffffff fffffffd", bus.hi, bus.lo);
        end
        do_op(3'd3, 32'd7, 32'd0);
        total++;
        if (bus.hi !== 32'd7 || bus.lo !== 32'hFFFF_FFFF || bus.div_zero !== 1'b1) begin
            bad++; $display("FAIL divu_zero hi=%h lo=%h dz=%b required 00000007 ffffffff 1", bus.hi, bus.lo, bus.div_zero);
        end
        do_op(3'd0, 32'd6, 32'd7);
        total++;
        if (bus.div_zero !== 1'b1) begin
            bad++; $display("FAIL dz_kept_by_mult dz=%b required 1", bus.div_zero);
        end
        do_op(3'd3, 32'd9, 32'd3);
        total++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd3 || bus.div_zero !== 1'b0) begin
            bad++; $display("FAIL divu_vec hi=%h lo=%h dz=%b required 00000000 00000003 0", bus.hi, bus.lo, bus.div_zero);
        end
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        total++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
            bad++; $display("FAIL div_overflow hi=%h lo=%h required 00000000 80000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 3)), pick(), pick());
        end
    endtask

    task automatic test_move();
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234_5678; bus.cancel = 1'b0;
        step();
        exp_hi = 32'h1234_5678;
        bus.op = 3'd5; bus.a = 32'h9ABC_DEF0;
        total++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL mthi hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h busy=0 done=0",
                            bus.hi, bus.lo, bus.busy, bus.done, exp_hi, exp_lo);
        end
        step();
        exp_lo = 32'h9ABC_DEF0;
        bus.op = 3'(6 + $urandom_range(0, 1)); bus.a = W'($urandom);
        total++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL mtlo hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h busy=0 done=0",
                            bus.hi, bus.lo, bus.busy, bus.done, exp_hi, exp_lo);
        end
        step();
        bus.start = 1'b0;
        total++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL reserved_op hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h busy=0 done=0",
                            bus.hi, bus.lo, bus.busy, bus.done, exp_hi, exp_lo);
        end
    endtask

    task automatic test_cancel();
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd100; bus.b = 32'd200; bus.cancel = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        bus.start = 1'b1; bus.op = 3'd3;
        step();
        bus.start = 1'b0; bus.cancel = 1'b1;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL cancel_pre busy=%b required 1", bus.busy);
        end
        step();
        bus.cancel = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            bad++; $display("FAIL cancel_run busy=%b done=%b hi=%h lo=%h required busy=0 done=0 hi=%h lo=%h",
                            bus.busy, bus.done, bus.hi, bus.lo, exp_hi, exp_lo);
        end
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL cancel_no_queue busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        bus.start = 1'b1; bus.op = 3'd4; bus.a = ~exp_hi; bus.cancel = 1'b1;
        step();
        bus.start = 1'b0; bus.cancel = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== exp_hi) begin
            bad++; $display("FAIL cancel_idle_blocks busy=%b hi=%h required busy=0 hi=%h", bus.busy, bus.hi, exp_hi);
        end
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd5; bus.b = 32'd0;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < DIVC - 1; k++) step();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo || bus.div_zero !== exp_dz) begin
            bad++; $display("FAIL cancel_final busy=%b done=%b hi=%h lo=%h dz=%b required busy=0 done=0 hi=%h lo=%h dz=%b",
                            bus.busy, bus.done, bus.hi, bus.lo, bus.div_zero, exp_hi, exp_lo, exp_dz);
        end
        step();
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL cancel_final_done done=%b required 0", bus.done);
        end
    endtask

    task automatic test_reset_mid();
        do_op(3'd3, 32'd4, 32'd0);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd1000; bus.b = 32'd7;
        step();
        bus.start = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            bad++; $display("FAIL async_reset busy=%b done=%b dz=%b hi=%h lo=%h required all zero",
                            bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
        end
        step();
        step();
        reset_n = 1'b1;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        step();
        do_op(3'd2, 32'hFFFF_FF00, 32'd7);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        step();
        step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_directed();
        test_random();
        test_move();
        test_cancel();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
